predict_sequencer: RTL

Control block for the perceptron branch-predictor datapath: debounces the two push-buttons, turns each press into one training step, and sequences that step. A step is compare, decide, optional learn pulse, then neuron-update pulse. It also keeps hit/total statistics and drives the accuracy LEDs. It sits between the board keys and the neurons / weight_module / norm / prediction instances, replacing the top-level inline FSM.

---
 rtl/predict_sequencer_if.sv | 13 +
 rtl/predict_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/predict_sequencer_if.sv
// Datapath-side bus of the predictor sequencer: prediction/norm in,
// current input and step pulses out.
interface predict_sequencer_if;
  logic signed [9:0] y;
  logic signed [9:0] abs_w;
  logic        [1:0] xin;
  logic              learn_trigger;
  logic              update_trigger;
  logic              busy;

  modport master (input y, abs_w, output xin, learn_trigger, update_trigger, busy);
  modport slave  (output y, abs_w, input xin, learn_trigger, update_trigger, busy);
endinterface

// File: rtl/predict_sequencer.sv
// Key debounce, press arbitration and training-step sequencing for the
// perceptron predictor, with hit/total statistics and accuracy LEDs.
module predict_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic CLOCK_50,
  input  logic rst_n,
  input  logic key,
  output logic press
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          s1, s2, deb;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      deb   <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= key;
      s2    <= s1;
      press <= 1'b0;
      if (s2 == deb) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        // Only falling edges (release->press) produce an event.
        deb   <= s2;
        cnt   <= '0;
        press <= ~s2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module predict_sequencer #(
  parameter int                 DEBOUNCE_CYCLES = 16,
  parameter int                 CNT_W           = 10,
  parameter logic signed [9:0]  GAMMA           = 10'sd45
) (
  input  logic                 CLOCK_50,
  input  logic                 rst_n,
  input  logic                 key0,
  input  logic                 key1,
  predict_sequencer_if.master  dp,
  output logic                 dropped,
  output logic [CNT_W-1:0]     hits,
  output logic [CNT_W-1:0]     total,
  output logic [7:0]           led
);
  typedef enum logic [2:0] {S_IDLE, S_COMPARE, S_DECIDE, S_LEARN, S_UPDATE} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t             state;
  logic               false_pred;
  logic [1:0]         keys, ev;
  logic [9:0]         abs_y;
  logic signed [19:0] lhs, rhs;
  logic               learn_now;
  logic [CNT_W-1:0]   hit_inc;
  logic [CNT_W+7:0]   quot;
  logic [7:0]         led_next;

  assign keys = {key1, key0};

  for (genvar k = 0; k < 2; k++) begin : g_key
    predict_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .CLOCK_50 (CLOCK_50),
      .rst_n    (rst_n),
      .key      (keys[k]),
      .press    (ev[k])
    );
  end

  // |y| with -512 saturated to 511; margin compares Q8.10 products.
  always_comb begin
    abs_y = dp.y;
    if (dp.y[9]) abs_y = (dp.y == 10'sh200) ? 10'd511 : 10'(-dp.y);
  end

  assign lhs       = $signed({5'b0, abs_y, 5'b0});
  assign rhs       = 20'(GAMMA) * 20'(dp.abs_w);
  assign learn_now = false_pred | (lhs <= rhs);
  assign hit_inc   = {{(CNT_W-1){1'b0}}, ~false_pred};

  always_comb begin
    led_next = '0;
    quot     = {hits, 8'b0} / {8'b0, total};
    if (total != '0) led_next = (quot > (CNT_W+8)'(255)) ? 8'hFF : quot[7:0];
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      false_pred        <= 1'b0;
      dp.xin            <= 2'b01;
      dp.learn_trigger  <= 1'b0;
      dp.update_trigger <= 1'b0;
      dp.busy           <= 1'b0;
      dropped           <= 1'b0;
      hits              <= '0;
      total             <= '0;
      led               <= '0;
    end else begin
      dp.learn_trigger  <= 1'b0;
      dp.update_trigger <= 1'b0;
      led               <= led_next;
      // Simultaneous events lose one; any event outside IDLE is lost.
      dropped           <= (state == S_IDLE) ? &ev : |ev;
      case (state)
        S_IDLE: begin
          if (|ev) begin
            dp.xin  <= ev[1] ? 2'b11 : 2'b01;
            dp.busy <= 1'b1;
            state   <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          false_pred <= dp.xin[1] ^ dp.y[9];
          state      <= S_DECIDE;
        end
        S_DECIDE: begin
          if (total == {CNT_W{1'b1}}) begin
            total <= (total >> 1) + ONE;
            hits  <= (hits >> 1) + hit_inc;
          end else begin
            total <= total + ONE;
            hits  <= hits + hit_inc;
          end
          if (learn_now) begin
            dp.learn_trigger <= 1'b1;
            state            <= S_LEARN;
          end else begin
            dp.update_trigger <= 1'b1;
            state             <= S_UPDATE;
          end
        end
        S_LEARN: begin
          dp.update_trigger <= 1'b1;
          state             <= S_UPDATE;
        end
        S_UPDATE: begin
          dp.busy <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          dp.busy <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end
endmodule
